// File: rtl/fetch_sequencer_if.sv
// Bundle of decode-control, branch-resolution and instruction-memory signals
// around the fetch sequencer; the sequencer binds the slave modport.
interface fetch_sequencer_if;
  // Fetch handshake: w_imem_req high means w_pc_32 is valid and held stable;
  // w_imem_ack is the ready/complete strobe, and a transfer happens on any
  // rising clock edge where both are high. Nothing else completes a fetch.
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_br_pc_in_32;
  logic [31:0] w_target_32;
  logic        w_imem_ack;
  logic        w_imem_req;
  logic [31:0] w_pc_32;
  logic        w_if_valid;
  logic [31:0] w_if_pc_32;
  logic        w_timeout;
  logic        w_err;
  logic [1:0]  dbg_state;

  modport master (
    output w_stall, w_redirect, w_br_pc_in_32, w_target_32, w_imem_ack,
    input  w_imem_req, w_pc_32, w_if_valid, w_if_pc_32, w_timeout, w_err,
           dbg_state
  );

  modport slave (
    input  w_stall, w_redirect, w_br_pc_in_32, w_target_32, w_imem_ack,
    output w_imem_req, w_pc_32, w_if_valid, w_if_pc_32, w_timeout, w_err,
           dbg_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Registered fetch-PC sequencer: steps by 4, holds on decode stalls and
// applies branch/jump redirects after the delay slot has been fetched.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic             clock,
  input logic             reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [8:0] WAIT_LIM = 9'(MAX_WAIT);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        timeout;
  logic        err;
  logic        pending;
  logic [31:0] ds;
  logic [31:0] tgt;
  logic [7:0]  wait_cnt;

  logic        cap;
  logic        eff_pend;
  logic [31:0] eff_ds;
  logic [31:0] eff_tgt;
  logic        hit_ds;
  logic        hit_ds4;

  // A redirect arriving this cycle is folded in before the A/B/C decision so
  // that capture and application can happen on the same edge.
  always_comb begin
    cap      = bus.w_redirect && !pending;
    eff_pend = pending || cap;
    eff_ds   = cap ? (bus.w_br_pc_in_32 + 32'd4) : ds;
    eff_tgt  = cap ? bus.w_target_32 : tgt;
    hit_ds   = eff_pend && (pc == eff_ds);
    hit_ds4  = eff_pend && (pc == (eff_ds + 32'd4));
  end

  assign bus.w_imem_req = (state == FETCH);
  assign bus.w_pc_32    = pc;
  assign bus.w_if_valid = if_valid;
  assign bus.w_if_pc_32 = if_pc;
  assign bus.w_timeout  = timeout;
  assign bus.w_err      = err;
  assign bus.dbg_state  = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_pc    <= 32'd0;
      if_valid <= 1'b0;
      timeout  <= 1'b0;
      err      <= 1'b0;
      pending  <= 1'b0;
      ds       <= 32'd0;
      tgt      <= 32'd0;
      wait_cnt <= 8'd0;
    end else begin
      if (bus.w_redirect && pending) err <= 1'b1;
      if (cap) begin
        pending <= 1'b1;
        ds      <= bus.w_br_pc_in_32 + 32'd4;
        tgt     <= bus.w_target_32;
      end

      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          if (bus.w_imem_ack) begin
            wait_cnt <= 8'd0;
            if_pc    <= pc;
            if (hit_ds) begin
              if_valid <= 1'b1;
              pc       <= eff_tgt;
              pending  <= 1'b0;
            end else if (hit_ds4) begin
              // Word after the delay slot was already in flight: drop it.
              if_valid <= 1'b0;
              pc       <= eff_tgt;
              pending  <= 1'b0;
            end else begin
              if_valid <= 1'b1;
              pc       <= pc + 32'd4;
            end
            state <= bus.w_stall ? HOLD : FETCH;
          end else begin
            if_valid <= 1'b0;
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            if (({1'b0, wait_cnt} + 9'd1) >= WAIT_LIM) timeout <= 1'b1;
          end
        end

        HOLD: begin
          // Delay slot already presented and nothing outstanding: retarget now.
          if (hit_ds4) begin
            pc      <= eff_tgt;
            pending <= 1'b0;
          end
          if (!bus.w_stall) state <= FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scripted fetch streams with an
// expected-presentation queue checked one cycle after each ack.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clock;
  logic reset;
  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RST_PC), .MAX_WAIT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];
  logic chk_pend = 1'b0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    logic [32:0] exp;
    @(negedge clock);
    if (chk_pend) begin
      exp = exp_q.pop_front();
      check("present", {31'd0, bus.w_if_valid, bus.w_if_pc_32}, {31'd0, exp});
      chk_pend = 1'b0;
    end
    bus.w_imem_ack    = 1'b0;
    bus.w_redirect    = 1'b0;
    bus.w_stall       = 1'b0;
    bus.w_br_pc_in_32 = $urandom();
    bus.w_target_32   = $urandom();
  endtask

  task automatic fetch(input logic [31:0] exp_pc, input logic present, input logic stall_v);
    tick();
    check("req", {63'd0, bus.w_imem_req}, 64'd1);
    check("pc", {32'd0, bus.w_pc_32}, {32'd0, exp_pc});
    bus.w_imem_ack = 1'b1;
    bus.w_stall    = stall_v;
    exp_q.push_back({present, exp_pc});
    chk_pend = 1'b1;
  endtask

  task automatic fetch_redir(input logic [31:0] exp_pc, input logic present,
                             input logic [31:0] br, input logic [31:0] tgt);
    fetch(exp_pc, present, 1'b0);
    bus.w_redirect    = 1'b1;
    bus.w_br_pc_in_32 = br;
    bus.w_target_32   = tgt;
  endtask

  task automatic idle(input logic redir, input logic [31:0] br, input logic [31:0] tgt,
                      input logic stall_v);
    tick();
    bus.w_stall = stall_v;
    if (redir) begin
      bus.w_redirect    = 1'b1;
      bus.w_br_pc_in_32 = br;
      bus.w_target_32   = tgt;
    end
  endtask

  task automatic hold_chk(input logic [31:0] exp_if_pc);
    check("hold_req", {63'd0, bus.w_imem_req}, 64'd0);
    check("hold_valid", {63'd0, bus.w_if_valid}, 64'd1);
    check("hold_if_pc", {32'd0, bus.w_if_pc_32}, {32'd0, exp_if_pc});
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_req"}, {63'd0, bus.w_imem_req}, 64'd0);
    check({tag, "_pc"}, {32'd0, bus.w_pc_32}, {32'd0, RST_PC});
    check({tag, "_valid"}, {63'd0, bus.w_if_valid}, 64'd0);
    check({tag, "_if_pc"}, {32'd0, bus.w_if_pc_32}, 64'd0);
    check({tag, "_timeout"}, {63'd0, bus.w_timeout}, 64'd0);
    check({tag, "_err"}, {63'd0, bus.w_err}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.w_imem_ack = 1'b0;
    bus.w_redirect = 1'b0;
    bus.w_stall    = 1'b0;
    bus.w_br_pc_in_32 = 32'd0;
    bus.w_target_32   = 32'd0;
    repeat (2) @(negedge clock);
    reset_vals("rst");
    reset = 1'b1;
    chk_pend = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;

    // sequential stream, then Case A (redirect while delay slot outstanding)
    do_reset();
    fetch(32'h0040_0000, 1'b1, 1'b0);
    fetch(32'h0040_0004, 1'b1, 1'b0);
    fetch(32'h0040_0008, 1'b1, 1'b0);
    idle(1'b1, 32'h0040_0008, 32'h0040_0100, 1'b0);
    check("a_pc_held", {32'd0, bus.w_pc_32}, 64'h0040_000C);
    fetch(32'h0040_000C, 1'b1, 1'b0);
    fetch(32'h0040_0100, 1'b1, 1'b0);
    fetch(32'h0040_0104, 1'b1, 1'b0);

    // Case B: delay slot already presented, next word in flight
    do_reset();
    fetch(32'h0040_0000, 1'b1, 1'b0);
    fetch(32'h0040_0004, 1'b1, 1'b0);
    fetch(32'h0040_0008, 1'b1, 1'b0);
    fetch(32'h0040_000C, 1'b1, 1'b0);
    idle(1'b1, 32'h0040_0008, 32'h0040_0100, 1'b0);
    fetch(32'h0040_0010, 1'b0, 1'b0);
    fetch(32'h0040_0100, 1'b1, 1'b0);

    // same-cycle redirect and ack of the delay slot
    fetch_redir(32'h0040_0104, 1'b1, 32'h0040_0100, 32'h0040_0800);
    fetch(32'h0040_0800, 1'b1, 1'b0);

    // stall for 3 cycles, then Case C with a target that wraps
    do_reset();
    fetch(32'h0040_0000, 1'b1, 1'b0);
    fetch(32'h0040_0004, 1'b1, 1'b1);
    idle(1'b0, 32'd0, 32'd0, 1'b1);
    hold_chk(32'h0040_0004);
    idle(1'b0, 32'd0, 32'd0, 1'b1);
    hold_chk(32'h0040_0004);
    idle(1'b0, 32'd0, 32'd0, 1'b0);
    hold_chk(32'h0040_0004);
    fetch(32'h0040_0008, 1'b1, 1'b0);
    fetch(32'h0040_000C, 1'b1, 1'b1);
    idle(1'b1, 32'h0040_0008, 32'hFFFF_FFFC, 1'b1);
    hold_chk(32'h0040_000C);
    idle(1'b0, 32'd0, 32'd0, 1'b0);
    hold_chk(32'h0040_000C);
    check("c_pc_retarget", {32'd0, bus.w_pc_32}, 64'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 1'b1, 1'b0);
    fetch(32'h0000_0000, 1'b1, 1'b0);
    fetch(32'h0000_0004, 1'b1, 1'b0);

    // timeout after 15 wait cycles, then normal completion
    do_reset();
    fetch(32'h0040_0000, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      idle(1'b0, 32'd0, 32'd0, 1'($urandom_range(0, 1)));
      check("to_early", {63'd0, bus.w_timeout}, 64'd0);
    end
    fetch(32'h0040_0004, 1'b1, 1'b0);
    check("to_set", {63'd0, bus.w_timeout}, 64'd1);
    fetch(32'h0040_0008, 1'b1, 1'b0);
    check("to_sticky", {63'd0, bus.w_timeout}, 64'd1);

    // double redirect: error flag, first target wins
    fetch(32'h0040_000C, 1'b1, 1'b0);
    idle(1'b1, 32'h0040_000C, 32'h0040_0200, 1'b0);
    idle(1'b0, 32'd0, 32'd0, 1'b0);
    check("err_clear", {63'd0, bus.w_err}, 64'd0);
    idle(1'b1, 32'h0040_0020, 32'h0040_0500, 1'b0);
    fetch(32'h0040_0010, 1'b1, 1'b0);
    check("err_set", {63'd0, bus.w_err}, 64'd1);
    fetch(32'h0040_0200, 1'b1, 1'b0);
    fetch(32'h0040_0204, 1'b1, 1'b0);
    idle(1'b0, 32'd0, 32'd0, 1'b0);
    check("err_sticky", {63'd0, bus.w_err}, 64'd1);

    // asynchronous reset in the middle of an outstanding access
    #($urandom_range(1, 3));
    reset = 1'b0;
    #1;
    reset_vals("async");
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    fetch(32'h0040_0000, 1'b1, 1'b0);
    fetch(32'h0040_0004, 1'b1, 1'b0);
    idle(1'b0, 32'd0, 32'd0, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
